// File: rtl/regfile_writer_pkg.sv
// regfile_writer shared definitions.
// Defaults, address-width helper and slot-select encoding.
package regfile_writer_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int QDEPTH_DEF = 4;

  // Write slot owner for the current cycle
  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_PIPE,
    SEL_AUX
  } sel_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_writer_if.sv
// Auxiliary result handshake into the write-port manager.
// Long-latency units are the master side.
interface regfile_writer_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
);

  logic             valid;
  logic             ready;
  logic [ADDR-1:0]  dst;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output dst,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  dst,
    input  data,
    output ready
  );

endinterface

// File: rtl/regfile_writer_wb_fifo.sv
// In-order writeback FIFO for out-of-band results.
// Exposes a per-entry register match vector for hazard checks.
module wb_fifo
  import regfile_writer_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int ADDR   = 5,
  parameter  int QDEPTH = QDEPTH_DEF,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR-1:0]   push_reg,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [ADDR-1:0]   head_reg,
  output logic [WIDTH-1:0]  head_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  input  logic [ADDR-1:0]   chk_reg1,
  input  logic [ADDR-1:0]   chk_reg2,
  output logic [QDEPTH-1:0] match1,
  output logic [QDEPTH-1:0] match2
);

  // Entry layout: {reg, data}
  logic [ADDR+WIDTH-1:0] mem [QDEPTH];
  logic [QDEPTH-1:0]     vld;
  logic [QDEPTH-1:0]     vld_n;
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;

  always_comb begin
    vld_n = vld;
    if (pop) vld_n[rp] = 1'b0;
    if (push) vld_n[wp] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      vld   <= vld_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {push_reg, push_data};
  end

  assign head_reg  = mem[rp][ADDR+WIDTH-1:WIDTH];
  assign head_data = mem[rp][WIDTH-1:0];
  assign empty     = (count == '0);
  assign full      = (count == CW'(QDEPTH));

  for (genvar i = 0; i < QDEPTH; i++) begin : g_match
    assign match1[i] = vld[i] &&
      (mem[i][ADDR+WIDTH-1:WIDTH] == chk_reg1);
    assign match2[i] = vld[i] &&
      (mem[i][ADDR+WIDTH-1:WIDTH] == chk_reg2);
  end

endmodule

// File: rtl/regfile_writer.sv
// Register-file write-port manager: pipeline writeback
// has priority, out-of-band results wait in a FIFO.
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int QDEPTH = QDEPTH_DEF,
  localparam int ADDR   = addr_w(DEPTH),
  localparam int CW     = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [ADDR-1:0]  pipe_reg,
  input  logic [WIDTH-1:0] pipe_data,
  regfile_writer_if.slave  aux,
  output logic             regwrite,
  output logic [ADDR-1:0]  wreg,
  output logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  chk_reg1,
  input  logic [ADDR-1:0]  chk_reg2,
  output logic             chk_pend1,
  output logic             chk_pend2,
  output logic             q_full,
  output logic [CW-1:0]    q_count
);

  logic              pipe_hit;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic [ADDR-1:0]   head_reg;
  logic [WIDTH-1:0]  head_data;
  logic [QDEPTH-1:0] match1;
  logic [QDEPTH-1:0] match2;
  sel_e              sel;

  // A pipeline write to r0 is an idle slot
  assign pipe_hit = pipe_we && (pipe_reg != '0);

  always_comb begin
    sel = SEL_IDLE;
    unique case (1'b1)
      pipe_hit:              sel = SEL_PIPE;
      !pipe_hit && !q_empty: sel = SEL_AUX;
      default:               sel = SEL_IDLE;
    endcase
  end

  assign pop       = (sel == SEL_AUX);
  assign aux.ready = !reset && !q_full;
  assign push      = aux.valid && aux.ready &&
                     (aux.dst != '0);

  wb_fifo #(
    .WIDTH  (WIDTH),
    .ADDR   (ADDR),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_reg  (aux.dst),
    .push_data (aux.data),
    .pop       (pop),
    .head_reg  (head_reg),
    .head_data (head_data),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count),
    .chk_reg1  (chk_reg1),
    .chk_reg2  (chk_reg2),
    .match1    (match1),
    .match2    (match2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
    end else begin
      unique case (sel)
        SEL_PIPE: begin
          regwrite <= 1'b1;
          wreg     <= pipe_reg;
          wdata    <= pipe_data;
        end
        SEL_AUX: begin
          regwrite <= 1'b1;
          wreg     <= head_reg;
          wdata    <= head_data;
        end
        default: regwrite <= 1'b0;
      endcase
    end
  end

  assign chk_pend1 = (chk_reg1 != '0) && ((|match1) ||
                     (regwrite && (wreg == chk_reg1)));
  assign chk_pend2 = (chk_reg2 != '0) && ((|match2) ||
                     (regwrite && (wreg == chk_reg2)));

endmodule
